// File: rtl/mem_access_ctrl.sv
// Load/store bridge between the EX/MEM pipeline stages and a req/addr_ok/data_ok SRAM bus.
// Latency: the request is combinational in EX; load data returns in MEM on data_ok, or from a buffer while MEM is stalled.
// Backpressure: EX is held until addr_ok; MEM is held until data_ok; at most one transaction is outstanding.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  // EX side
  input  logic        ex_valid,
  input  logic        ex_mem_req,
  input  logic        ex_mem_we,
  input  logic [1:0]  ex_mem_size,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_mem_wdata,
  input  logic        ex_allowout,
  output logic        ex_readygo,
  // MEM side
  input  logic        mem_allowout,
  output logic        mem_readygo,
  output logic [31:0] mem_rdata,
  input  logic        flush,
  // SRAM bus
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // no transaction outstanding
    ST_WAIT   = 2'd1,  // address accepted, waiting for data_ok
    ST_HOLD   = 2'd2,  // data returned while MEM was stalled, held in buffer
    ST_CANCEL = 2'd3   // flushed while waiting, drain the stale data_ok
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_rdata_buf;
  logic        w_req;
  logic        w_addr_hs;
  logic        w_capture;

  // Request only when idle and both EX and the MEM stage can take the op.
  assign w_req     = (r_state == ST_IDLE) & ex_valid & ex_mem_req & ex_allowout & ~flush;
  assign w_addr_hs = w_req & data_sram_addr_ok;
  // Data arrived but MEM cannot consume it this cycle: keep a copy.
  assign w_capture = (r_state == ST_WAIT) & data_sram_data_ok & ~flush & ~mem_allowout;

  assign data_sram_req  = w_req;
  assign data_sram_wr   = ex_mem_we;
  assign data_sram_addr = ex_mem_addr;
  assign data_sram_size = (ex_mem_size == 2'd3) ? 2'd2 : ex_mem_size;

  // A memory op leaves EX only in the cycle its address is accepted.
  assign ex_readygo  = ~ex_mem_req | w_addr_hs;
  assign mem_readygo = ~((r_state == ST_WAIT) & ~data_sram_data_ok);
  assign mem_rdata   = (r_state == ST_HOLD) ? r_rdata_buf : data_sram_rdata;

  // Byte-lane strobes and lane-replicated store data.
  always_comb begin
    data_sram_wstrb = 4'b0000;
    data_sram_wdata = ex_mem_wdata;
    case (ex_mem_size)
      2'd0: begin
        data_sram_wstrb = 4'b0001 << ex_mem_addr[1:0];
        data_sram_wdata = {4{ex_mem_wdata[7:0]}};
      end
      2'd1: begin
        data_sram_wstrb = 4'b0011 << {ex_mem_addr[1], 1'b0};
        data_sram_wdata = {2{ex_mem_wdata[15:0]}};
      end
      default: begin
        data_sram_wstrb = 4'b1111;
      end
    endcase
    if (!ex_mem_we) begin
      data_sram_wstrb = 4'b0000;
    end
  end

  // Next-state logic; data_ok is ignored outside WAIT and CANCEL.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_addr_hs) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (data_sram_data_ok) begin
          if (flush || mem_allowout) w_state_nxt = ST_IDLE;
          else                       w_state_nxt = ST_HOLD;
        end else if (flush) begin
          w_state_nxt = ST_CANCEL;
        end
      end
      ST_HOLD: begin
        if (flush || mem_allowout) w_state_nxt = ST_IDLE;
      end
      ST_CANCEL: begin
        if (data_sram_data_ok) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Load-data buffer used while MEM is stalled.
  always_ff @(posedge clk) begin
    if (rst)            r_rdata_buf <= 32'd0;
    else if (w_capture) r_rdata_buf <= data_sram_rdata;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  in  1  clock, all state updates on posedge; rst  in  1  reset.
REQ-002 The EX-side ports SHALL be:
- ex_valid  in  1  EX holds a valid instruction
- ex_mem_req  in  1  instruction is a load/store
- ex_mem_we  in  1  1=store, 0=load
- ex_mem_size  in  2  0=byte, 1=half, 2=word
- ex_mem_addr  in  32  byte address
- ex_mem_wdata  in  32  unaligned store data, value in the low bits
- ex_allowout  in  1  MEM stage allowin
- ex_readygo  out  1  EX may advance
REQ-003 The MEM-side ports SHALL be:
- mem_allowout  in  1  WB stage allowin
- mem_readygo  out  1  MEM may advance
- mem_rdata  out  32  load data for MEM write-back mux
- flush  in  1  cancel EX/MEM contents
REQ-004 The SRAM bus ports SHALL be:
- data_sram_req  out  1
- data_sram_wr  out  1
- data_sram_size  out  2
- data_sram_wstrb  out  4
- data_sram_addr  out  32
- data_sram_wdata  out  32
- data_sram_addr_ok  in  1
- data_sram_data_ok  in  1
- data_sram_rdata  in  32

Function
REQ-005 The FSM SHALL have four states: IDLE, WAIT (accepted, awaiting data_ok), HOLD (data returned, MEM stalled), CANCEL (flushed, draining). At most one transaction SHALL be outstanding.
REQ-006 data_sram_req SHALL be combinational: state==IDLE & ex_valid & ex_mem_req & ex_allowout & !flush.
REQ-007 Address handshake SHALL be data_sram_req & data_sram_addr_ok, taking IDLE->WAIT at the next edge.
REQ-008 ex_readygo SHALL be 1 when !ex_mem_req. Otherwise it SHALL equal the address handshake, so a memory op in EX advances only in its handshake cycle.
REQ-009 data_sram_addr SHALL equal ex_mem_addr. data_sram_wr SHALL equal ex_mem_we. data_sram_size SHALL equal ex_mem_size, with size 3 driven as 2.
REQ-010 data_sram_wstrb SHALL be 0 for loads. For stores it SHALL be:
- byte: 4'b0001<<addr[1:0]
- half: 4'b0011<<{addr[1],0}
- word/size3: 4'b1111
REQ-011 data_sram_wdata SHALL be:
- byte: {4{wdata[7:0]}}
- half: {2{wdata[15:0]}}
- otherwise: wdata
REQ-012 In WAIT with data_ok and mem_allowout, the block SHALL go to IDLE. With data_ok and !mem_allowout, it SHALL capture data_sram_rdata into a 32-bit buffer and go to HOLD.
REQ-013 In HOLD, mem_allowout SHALL take the block to IDLE.
REQ-014 mem_readygo SHALL be 0 only in WAIT without data_ok. It SHALL be 1 in WAIT with data_ok, and 1 in IDLE, HOLD and CANCEL.
REQ-015 mem_rdata SHALL be the buffer in HOLD, and data_sram_rdata in all other states.
REQ-016 flush SHALL act as follows:
- IDLE: suppresses req, state unchanged.
- WAIT without data_ok: go to CANCEL.
- WAIT with data_ok: go to IDLE.
- HOLD: go to IDLE.
- CANCEL: no effect.
REQ-017 In CANCEL, req SHALL be 0. data_ok SHALL be consumed and discarded (buffer unchanged), with CANCEL->IDLE.
REQ-018 A new request SHALL issue only from IDLE. Back-to-back memory ops therefore incur at least one bubble; this is intended.
REQ-019 data_ok SHALL be ignored in IDLE and HOLD (protocol violation, no state change).

Reset
REQ-020 Reset SHALL set state=IDLE and buffer=0, overriding every other input that cycle, including a mid-transaction reset from WAIT/HOLD/CANCEL.
REQ-021 During and after reset with ex_valid=0, outputs SHALL be req=0, mem_readygo=1 and mem_rdata=data_sram_rdata. Any response to a transaction in flight at reset is the bus's responsibility.

Verification
REQ-022 Word load: addr=0x1000, addr_ok same cycle, data_ok 2 cycles later with rdata=0xDEADBEEF, mem_allowout=1 -> req for 1 cycle, ex_readygo=1 that cycle, mem_readygo=0 for 1 cycle then 1, mem_rdata=0xDEADBEEF, back to IDLE.
REQ-023 Byte store: addr=0x1003, wdata=0x000000A5, size=0 -> wstrb=4'b1000, wdata=0xA5A5A5A5, wr=1. Half store: addr=0x1002 -> wstrb=4'b1100.
REQ-024 addr_ok low for 3 cycles -> req held 4 cycles with stable addr, ex_readygo=0 for 3 cycles, single transaction.
REQ-025 data_ok=1 with rdata=0x12345678 while mem_allowout=0 for 2 cycles -> HOLD, mem_rdata stays 0x12345678 while bus rdata changes, IDLE after mem_allowout=1.
REQ-026 flush in WAIT -> CANCEL, req=0 even with ex_valid&ex_mem_req, data_ok discarded, next request issues the cycle after CANCEL->IDLE. rst asserted in WAIT -> IDLE, buffer=0 next cycle.
